seg_scan_display: RTL and testbench

//  Six-digit multiplexed 7-segment driver; the read side of the timekeeping BCD digit bus.

---
 rtl/seg_scan_display.sv | 200 ++++++++++++++++++++
 tb/tb_seg_scan_display.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// ---------------------------------------------------------------------------
// seg_scan_display
// Six-digit multiplexed 7-segment driver sitting on the read side of the
// timekeeping BCD digit bus. The six digits are snapshotted once per scan
// frame, then shown one slot per SCAN_DIV clocks. Each slot change shows one
// all-off (deghost) cycle before the next digit lights.
//
// Optional feature macro: BLINK_EN
//   defined   -> in time-adjust mode (i_mk == 2'b10) the field selected by
//                i_k1 (minutes = slots 2,3; hours = slots 4,5) blanks every
//                other BLINK_FRAMES-frame period.
//   undefined -> no blink logic; i_mk and i_k1 are ignored.
//
// Parameters
//   SCAN_DIV      clocks per digit slot (>= 2)
//   SEG_ACT_LOW   1: segment outputs active-low
//   DIG_ACT_LOW   1: digit enables active-low
//   BLINK_FRAMES  frames per blink half-period (BLINK_EN only)
//
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_mk [1:0]   mode, 2'b10 = time-adjust
//   i_k1 [1:0]   adjust select, bit 0: 0 = minutes, 1 = hours
//   i_a/i_b      second low/high BCD digit
//   i_c/i_d      minute low/high BCD digit
//   i_e/i_f      hour low/high BCD digit
//   o_seg [7:0]  {dp,g,f,e,d,c,b,a} segment drive
//   o_dig [5:0]  digit enable, bit i = slot i (slot 0 = i_a, rightmost)
// ---------------------------------------------------------------------------
module seg_scan_display #(
    parameter int SCAN_DIV     = 50000,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit DIG_ACT_LOW  = 1'b1,
    parameter int BLINK_FRAMES = 256
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_mk,
    input  logic [1:0] i_k1,
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [3:0] i_c,
    input  logic [3:0] i_d,
    input  logic [3:0] i_e,
    input  logic [3:0] i_f,
    output logic [7:0] o_seg,
    output logic [5:0] o_dig
);

    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [7:0]       SEG_MASK = {8{SEG_ACT_LOW}};
    localparam logic [5:0]       DIG_MASK = {6{DIG_ACT_LOW}};

    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_idx;
    logic [5:0][3:0]  r_snap;
    logic             r_tick1;
    logic             r_load;
    logic [7:0]       r_seg;
    logic [5:0]       r_dig;

    logic             w_tick;
    logic             w_frame;
    logic             w_blank;
    logic [3:0]       w_digit;
    logic [6:0]       w_glyph;
    logic             w_dp;
    logic [7:0]       w_segRaw;

    assign w_tick  = (r_div == DIV_LAST);
    assign w_frame = w_tick && (r_idx == 3'd5);

    // Slot timing and the frame snapshot. The snapshot is taken on the same
    // edge that wraps the slot index back to 0, so a whole frame always shows
    // one consistent set of digits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div  <= '0;
            r_idx  <= '0;
            r_snap <= '0;
        end else if (w_tick) begin
            r_div <= '0;
            if (r_idx == 3'd5) begin
                r_idx  <= '0;
                r_snap <= {i_f, i_e, i_d, i_c, i_b, i_a};
            end else begin
                r_idx <= r_idx + 3'd1;
            end
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Current slot's digit from the snapshot.
    always_comb begin
        w_digit = 4'd0;
        case (r_idx)
            3'd0:    w_digit = r_snap[0];
            3'd1:    w_digit = r_snap[1];
            3'd2:    w_digit = r_snap[2];
            3'd3:    w_digit = r_snap[3];
            3'd4:    w_digit = r_snap[4];
            3'd5:    w_digit = r_snap[5];
            default: w_digit = 4'd0;
        endcase
    end

    // BCD to active-high {g..a}; non-BCD codes show nothing.
    always_comb begin
        w_glyph = 7'h00;
        case (w_digit)
            4'd0:    w_glyph = 7'h3F;
            4'd1:    w_glyph = 7'h06;
            4'd2:    w_glyph = 7'h5B;
            4'd3:    w_glyph = 7'h4F;
            4'd4:    w_glyph = 7'h66;
            4'd5:    w_glyph = 7'h6D;
            4'd6:    w_glyph = 7'h7D;
            4'd7:    w_glyph = 7'h07;
            4'd8:    w_glyph = 7'h7F;
            4'd9:    w_glyph = 7'h6F;
            default: w_glyph = 7'h00;
        endcase
    end

    // Separators sit after the seconds pair and after the minutes pair.
    assign w_dp     = (r_idx == 3'd2) || (r_idx == 3'd4);
    assign w_segRaw = w_blank ? 8'h00 : {w_dp, w_glyph};

`ifdef BLINK_EN
    localparam int              FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0] r_frameCnt;
    logic            r_phase;
    logic            w_unusedK1Hi;

    assign w_unusedK1Hi = i_k1[1];

    // Blink phase flips every BLINK_FRAMES frame boundaries.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frameCnt <= '0;
            r_phase    <= 1'b0;
        end else if (w_frame) begin
            if (r_frameCnt == FC_LAST) begin
                r_frameCnt <= '0;
                r_phase    <= ~r_phase;
            end else begin
                r_frameCnt <= r_frameCnt + FC_W'(1);
            end
        end
    end

    // Mode is looked at when a slot is loaded, so a change shows from the
    // next slot on.
    always_comb begin
        w_blank = 1'b0;
        if ((i_mk == 2'b10) && r_phase) begin
            if (i_k1[0]) begin
                w_blank = (r_idx == 3'd4) || (r_idx == 3'd5);
            end else begin
                w_blank = (r_idx == 3'd2) || (r_idx == 3'd3);
            end
        end
    end
`else
    logic w_unusedCfg;

    assign w_unusedCfg = ^{i_mk, i_k1, BLINK_FRAMES[0]};
    assign w_blank     = 1'b0;
`endif

    // Output stage. Reset behaves as if a tick just happened, so slot 0
    // lights two cycles after release. The cycle after a tick blanks the
    // digit enables; the cycle after that loads the new digit and segments.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick1 <= 1'b1;
            r_load  <= 1'b0;
            r_dig   <= DIG_MASK;
            r_seg   <= SEG_MASK;
        end else begin
            r_tick1 <= w_tick;
            r_load  <= r_tick1;
            if (r_tick1) begin
                r_dig <= DIG_MASK;
            end else if (r_load) begin
                r_dig <= (6'd1 << r_idx) ^ DIG_MASK;
                r_seg <= w_segRaw ^ SEG_MASK;
            end
        end
    end

    assign o_seg = r_seg;
    assign o_dig = r_dig;

endmodule

// File: tb/tb_seg_scan_display.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_display
// Self-checking bench for seg_scan_display with SCAN_DIV=4, active-low
// segments and digits, BLINK_FRAMES=2. The reference model works from clock
// edges counted since reset release: which slot is shown, which frame it
// belongs to and when the digits are captured all follow from plain integer
// arithmetic on that count. Builds with or without BLINK_EN.
// ---------------------------------------------------------------------------
module tb_seg_scan_display;

    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FRAME = 6 * SD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mk = 2'b00;
    logic [1:0] k1 = 2'b00;
    logic [3:0] dA = 4'd0, dB = 4'd0, dC = 4'd0, dD = 4'd0, dE = 4'd0, dF = 4'd0;
    logic [7:0] seg;
    logic [5:0] dig;

    int nCompared = 0;
    int nMismatch = 0;

    seg_scan_display #(
        .SCAN_DIV    (SD),
        .SEG_ACT_LOW (1'b1),
        .DIG_ACT_LOW (1'b1),
        .BLINK_FRAMES(BF)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_mk   (mk),
        .i_k1   (k1),
        .i_a    (dA),
        .i_b    (dB),
        .i_c    (dC),
        .i_d    (dD),
        .i_e    (dE),
        .i_f    (dF),
        .o_seg  (seg),
        .o_dig  (dig)
    );

    always #5 clk = ~clk;

    // Segment table, active-high {g..a}; anything past 9 is dark.
    function automatic logic [6:0] glyphOf(input logic [3:0] v);
        logic [6:0] table7 [10];
        table7 = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (v > 4'd9) return 7'h00;
        return table7[v];
    endfunction

    // Reference model: edge count since release drives everything.
    int         edgeN;
    logic [3:0] mSnap [6];
    logic [7:0] expSeg;
    logic [5:0] expDig;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edgeN  = 0;
            mSnap  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
            expSeg = 8'hFF;
            expDig = 6'h3F;
        end else begin : modelStep
            int         slot;
            int         frame;
            logic [7:0] raw;
            edgeN = edgeN + 1;
            if (edgeN % FRAME == 0) begin
                mSnap = '{dA, dB, dC, dD, dE, dF};
            end
            if ((edgeN - 1) % SD == 0) begin
                expDig = 6'h3F;
            end else begin
                slot  = ((edgeN - 2) / SD) % 6;
                frame = ((edgeN - 2) / SD) / 6;
                if ((edgeN - 2) % SD == 0) begin
                    raw = {(slot == 2 || slot == 4), glyphOf(mSnap[slot])};
`ifdef BLINK_EN
                    if (mk == 2'b10 && ((frame / BF) % 2 == 1) &&
                        (k1[0] ? (slot >= 4) : (slot == 2 || slot == 3))) begin
                        raw = 8'h00;
                    end
`endif
                    expSeg = ~raw;
                end
                expDig = ~(6'd1 << slot);
            end
        end
    end

    // Waits for a fresh entry into a given slot; times out after 200 cycles.
    task automatic waitForSlot(input int s, output bit found);
        logic [5:0] want;
        logic [5:0] prev;
        want  = ~(6'd1 << s);
        prev  = dig;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (dig === want && prev !== want) found = 1'b1;
            prev = dig;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, b, c, d, e, f);
        dA = a; dB = b; dC = c; dD = d; dE = e; dF = f;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        applyStimulus(4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4);
        repeat (3) @(negedge clk);
        nCompared++;
        if (dig !== 6'h3F) begin
            nMismatch++;
            $display("[TB] FAIL reset_dig: got %h want 3f", dig);
        end
        nCompared++;
        if (seg !== 8'hFF) begin
            nMismatch++;
            $display("[TB] FAIL reset_seg: got %h want ff", seg);
        end
        rst_n = 1'b1;
        @(negedge clk);
        nCompared++;
        if (dig !== 6'h3F) begin
            nMismatch++;
            $display("[TB] FAIL release_deghost: dig got %h want 3f", dig);
        end
        @(negedge clk);
        nCompared++;
        if (dig !== 6'h3E || seg !== 8'hC0) begin
            nMismatch++;
            $display("[TB] FAIL release_slot0: dig/seg got %h/%h want 3e/c0", dig, seg);
        end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            nCompared++;
            if (dig !== expDig || seg !== expSeg) begin
                nMismatch++;
                $display("[TB] FAIL frame0_model @%0d: dig/seg got %h/%h want %h/%h", edgeN, dig, seg, expDig, expSeg);
            end
        end
    endtask

    task automatic test_decode_pattern;
        bit found;
        applyStimulus(4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            nCompared++;
            if (dig !== expDig || seg !== expSeg) begin
                nMismatch++;
                $display("[TB] FAIL pattern_model @%0d: dig/seg got %h/%h want %h/%h", edgeN, dig, seg, expDig, expSeg);
            end
        end
        waitForSlot(0, found);
        nCompared++;
        if (!found || seg !== 8'h82) begin
            nMismatch++;
            $display("[TB] FAIL pattern_slot0: found=%0d seg got %h want 82", found, seg);
        end
        waitForSlot(2, found);
        nCompared++;
        if (!found || seg !== 8'h19) begin
            nMismatch++;
            $display("[TB] FAIL pattern_slot2: found=%0d seg got %h want 19", found, seg);
        end
        waitForSlot(5, found);
        nCompared++;
        if (!found || seg !== 8'hF9) begin
            nMismatch++;
            $display("[TB] FAIL pattern_slot5: found=%0d seg got %h want f9", found, seg);
        end
    endtask

    task automatic test_blank_codes;
        bit found;
        applyStimulus(4'd0, 4'd1, 4'hA, 4'd2, 4'd3, 4'd4);
        repeat (2 * FRAME) @(negedge clk);
        waitForSlot(2, found);
        nCompared++;
        if (!found || seg !== 8'h7F) begin
            nMismatch++;
            $display("[TB] FAIL blank_slot2: found=%0d seg got %h want 7f", found, seg);
        end
        applyStimulus(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        repeat (2 * FRAME) @(negedge clk);
        for (int s = 0; s < 6; s++) begin
            waitForSlot(s, found);
            nCompared++;
            if (!found || seg !== ((s == 2 || s == 4) ? 8'h7F : 8'hFF)) begin
                nMismatch++;
                $display("[TB] FAIL allF_slot%0d: found=%0d seg got %h", s, found, seg);
            end
        end
    endtask

    task automatic test_no_tearing;
        bit found;
        applyStimulus(4'd3, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0);
        repeat (2 * FRAME) @(negedge clk);
        waitForSlot(0, found);
        nCompared++;
        if (!found || seg !== 8'hB0) begin
            nMismatch++;
            $display("[TB] FAIL tear_slot0_old: found=%0d seg got %h want b0", found, seg);
        end
        dC = 4'd8;
        waitForSlot(2, found);
        nCompared++;
        if (!found || seg !== 8'h79) begin
            nMismatch++;
            $display("[TB] FAIL tear_slot2_same_frame: found=%0d seg got %h want 79", found, seg);
        end
        dA = 4'd7;
        waitForSlot(0, found);
        nCompared++;
        if (!found || seg !== 8'hF8) begin
            nMismatch++;
            $display("[TB] FAIL tear_slot0_new: found=%0d seg got %h want f8", found, seg);
        end
        waitForSlot(2, found);
        nCompared++;
        if (!found || seg !== 8'h00) begin
            nMismatch++;
            $display("[TB] FAIL tear_slot2_new: found=%0d seg got %h want 00", found, seg);
        end
    endtask

    task automatic test_random_scan;
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                nCompared++;
                if (dig !== expDig || seg !== expSeg) begin
                    nMismatch++;
                    $display("[TB] FAIL random_model @%0d: dig/seg got %h/%h want %h/%h", edgeN, dig, seg, expDig, expSeg);
                end
                if ($urandom_range(0, 9) == 0) begin
                    applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                end
            end
        end
    endtask

    task automatic test_blink;
        logic [1:0] mkSeq [3];
        logic [1:0] k1Seq [3];
        mkSeq = '{2'b10, 2'b00, 2'b10};
        k1Seq = '{2'b01, 2'b01, 2'b10};
        applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        for (int p = 0; p < 3; p++) begin
            mk = mkSeq[p];
            k1 = k1Seq[p];
            for (int i = 0; i < 6 * FRAME; i++) begin
                @(negedge clk);
                nCompared++;
                if (dig !== expDig || seg !== expSeg) begin
                    nMismatch++;
                    $display("[TB] FAIL blink_model p%0d @%0d: dig/seg got %h/%h want %h/%h", p, edgeN, dig, seg, expDig, expSeg);
                end
            end
        end
        mk = 2'b00;
    endtask

    task automatic test_reset_midscan;
        bit found;
        waitForSlot(3, found);
        nCompared++;
        if (!found) begin
            nMismatch++;
            $display("[TB] FAIL midreset_reach_slot3: got no slot 3, want slot 3");
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        nCompared++;
        if (dig !== 6'h3F || seg !== 8'hFF) begin
            nMismatch++;
            $display("[TB] FAIL midreset_blank: dig/seg got %h/%h want 3f/ff", dig, seg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            nCompared++;
            if (dig !== expDig || seg !== expSeg) begin
                nMismatch++;
                $display("[TB] FAIL midreset_model @%0d: dig/seg got %h/%h want %h/%h", edgeN, dig, seg, expDig, expSeg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode_pattern();
        test_blank_codes();
        test_no_tearing();
        test_random_scan();
        test_blink();
        test_reset_midscan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
